// File: rtl/pic_cascade_pkg.sv
// Shared types and constants for the PIC cascade / INTA sequencing logic.
package pic_cascade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        P1,
        GAP,
        P2
    } seq_state_t;

    localparam logic       MASTER              = 1'b1;
    localparam logic       SLAVE               = 1'b0;
    localparam logic [2:0] SPURIOUS_IR_DEFAULT = 3'd7;

endpackage

// File: rtl/inta_edge_sync.sv
// Multi-flop synchroniser for an asynchronous strobe pin, with one-cycle
// fall/rise pulses derived from the synchronised level.
module inta_edge_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_LEVEL}};
            prev_q <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[STAGES-1];
    assign rise = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/cascade_inta_sequencer.sv
// Two-pulse INTA sequencer: master drives CAS to the serviced slave or
// supplies the vector itself; a selected slave supplies its vector on pulse 2.
//
// state | meaning
// IDLE  | waiting for first INTA fall
// P1    | first INTA pulse; IR latched, CAS driven if a slave owns it
// GAP   | between pulses
// P2    | second INTA pulse; vector driven when this device owns it
module cascade_inta_sequencer
    import pic_cascade_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] SPURIOUS_IR = SPURIOUS_IR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INTA_n,
    input  logic       SP,
    input  logic       SNGL,
    input  logic [7:0] ICW2,
    input  logic [7:0] ICW3,
    input  logic       int_req,
    input  logic [2:0] highest_ir,
    input  logic [2:0] CAS_in,
    output logic [2:0] CAS_out,
    output logic       CAS_oe,
    output logic [7:0] vector_out,
    output logic       data_oe,
    output logic       set_isr,
    output logic [2:0] isr_index,
    output logic       freeze,
    output logic       ack_done
);

    seq_state_t state_q, state_d;
    logic [2:0] latched_ir_q, latched_ir_d;
    logic       selected_q, selected_d;
    logic       set_isr_q, set_isr_d;
    logic       ack_done_q, ack_done_d;
    logic       inta_fall, inta_rise;
    logic       master_mode, slave_mode, slave_present, drive_vector;
    logic       unused_icw2_low;

    inta_edge_sync #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (1'b1)
    ) u_inta_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INTA_n),
        .fall     (inta_fall),
        .rise     (inta_rise)
    );

    // Low vector bits come from the IR, not from ICW2.
    assign unused_icw2_low = ^ICW2[2:0];

    assign master_mode   = !SNGL && (SP == MASTER);
    assign slave_mode    = !SNGL && (SP == SLAVE);
    assign slave_present = ICW3[latched_ir_q];
    assign drive_vector  = SNGL || (master_mode && !slave_present)
                                || (slave_mode && selected_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            latched_ir_q <= 3'd0;
            selected_q   <= 1'b0;
            set_isr_q    <= 1'b0;
            ack_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            latched_ir_q <= latched_ir_d;
            selected_q   <= selected_d;
            set_isr_q    <= set_isr_d;
            ack_done_q   <= ack_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        latched_ir_d = latched_ir_q;
        selected_d   = selected_q;
        set_isr_d    = 1'b0;
        ack_done_d   = 1'b0;
        CAS_oe       = 1'b0;
        CAS_out      = 3'd0;
        data_oe      = 1'b0;
        vector_out   = 8'd0;
        freeze       = 1'b0;

        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    latched_ir_d = int_req ? highest_ir : SPURIOUS_IR;
                    set_isr_d    = int_req;
                    state_d      = P1;
                end
            end
            P1: begin
                if (inta_rise) begin
                    if (slave_mode)
                        selected_d = (CAS_in == ICW3[2:0]);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (inta_fall)
                    state_d = P2;
            end
            P2: begin
                if (inta_rise) begin
                    selected_d = 1'b0;
                    ack_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            freeze = 1'b1;
            if (master_mode && slave_present) begin
                CAS_oe  = 1'b1;
                CAS_out = latched_ir_q;
            end
        end
        if (state_q == P2 && drive_vector) begin
            data_oe    = 1'b1;
            vector_out = {ICW2[7:3], latched_ir_q};
        end
    end

    assign set_isr   = set_isr_q;
    assign ack_done  = ack_done_q;
    assign isr_index = latched_ir_q;

endmodule

// File: tb/tb_cascade_inta_sequencer.sv
// Randomised bench for the INTA sequencer against a per-sequence reference
// model of which device owns the CAS lines and the data bus.
module tb_cascade_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       INTA_n;
    logic       SP;
    logic       SNGL;
    logic [7:0] ICW2;
    logic [7:0] ICW3;
    logic       int_req;
    logic [2:0] highest_ir;
    logic [2:0] CAS_in;
    logic [2:0] CAS_out;
    logic       CAS_oe;
    logic [7:0] vector_out;
    logic       data_oe;
    logic       set_isr;
    logic [2:0] isr_index;
    logic       freeze;
    logic       ack_done;

    int n_vec  = 0;
    int n_miss = 0;
    int set_cnt = 0;
    int ack_cnt = 0;

    cascade_inta_sequencer #(
        .SYNC_STAGES (2),
        .SPURIOUS_IR (3'd7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .INTA_n     (INTA_n),
        .SP         (SP),
        .SNGL       (SNGL),
        .ICW2       (ICW2),
        .ICW3       (ICW3),
        .int_req    (int_req),
        .highest_ir (highest_ir),
        .CAS_in     (CAS_in),
        .CAS_out    (CAS_out),
        .CAS_oe     (CAS_oe),
        .vector_out (vector_out),
        .data_oe    (data_oe),
        .set_isr    (set_isr),
        .isr_index  (isr_index),
        .freeze     (freeze),
        .ack_done   (ack_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles-high counts; a correct one-cycle pulse adds exactly 1.
    always @(posedge clk) begin
        if (set_isr)  set_cnt <= set_cnt + 1;
        if (ack_done) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inta(input logic v);
        @(negedge clk);
        #2 INTA_n = v;
    endtask

    // One full INTA pair; optionally reset during the second pulse.
    task automatic run_seq(input logic sngl, input logic sp, input logic [7:0] icw2,
                           input logic [7:0] icw3, input logic req, input logic [2:0] hir,
                           input logic [2:0] cas, input logic abort_in_p2);
        logic [2:0] ir;
        logic       exp_cas, exp_drv;
        logic [7:0] exp_vec;
        int         s0, a0;

        SNGL = sngl; SP = sp; ICW2 = icw2; ICW3 = icw3;
        int_req = req; highest_ir = hir; CAS_in = cas;

        ir      = req ? hir : 3'd7;
        exp_cas = !sngl && sp && icw3[ir];
        if (sngl)
            exp_drv = 1'b1;
        else if (sp)
            exp_drv = !icw3[ir];
        else
            exp_drv = (cas == icw3[2:0]);
        exp_vec = {icw2[7:3], ir};

        wait_cycles(1);
        s0 = set_cnt;
        a0 = ack_cnt;

        set_inta(1'b0);
        wait_cycles(6);
        check("p1_freeze", freeze, 1'b1);
        check("p1_cas_oe", CAS_oe, exp_cas);
        check("p1_cas_out", CAS_out, exp_cas ? ir : 3'd0);
        check("p1_data_oe", data_oe, 1'b0);
        check("p1_isr_index", isr_index, ir);

        set_inta(1'b1);
        wait_cycles(6);
        check("gap_freeze", freeze, 1'b1);
        check("gap_cas_oe", CAS_oe, exp_cas);
        check("gap_data_oe", data_oe, 1'b0);

        set_inta(1'b0);
        wait_cycles(6);
        check("p2_freeze", freeze, 1'b1);
        check("p2_cas_oe", CAS_oe, exp_cas);
        check("p2_data_oe", data_oe, exp_drv);
        check("p2_vector", vector_out, exp_drv ? exp_vec : 8'd0);

        if (abort_in_p2) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_data_oe", data_oe, 1'b0);
            check("rst_cas_oe", CAS_oe, 1'b0);
            check("rst_freeze", freeze, 1'b0);
            check("rst_vector", vector_out, 8'd0);
            INTA_n = 1'b1;
            wait_cycles(3);
            rst_n = 1'b1;
            wait_cycles(6);
            check("rst_idle_freeze", freeze, 1'b0);
            return;
        end

        set_inta(1'b1);
        wait_cycles(6);
        check("end_freeze", freeze, 1'b0);
        check("end_cas_oe", CAS_oe, 1'b0);
        check("end_data_oe", data_oe, 1'b0);
        check("set_isr_count", set_cnt - s0, req ? 1 : 0);
        check("ack_done_count", ack_cnt - a0, 1);
    endtask

    initial begin
        rst_n = 1'b0; INTA_n = 1'b1; SP = 1'b1; SNGL = 1'b0;
        ICW2 = 8'h00; ICW3 = 8'h00; int_req = 1'b0; highest_ir = 3'd0; CAS_in = 3'd0;
        wait_cycles(3);
        check("reset_cas_oe", CAS_oe, 1'b0);
        check("reset_cas_out", CAS_out, 3'd0);
        check("reset_data_oe", data_oe, 1'b0);
        check("reset_vector", vector_out, 8'd0);
        check("reset_freeze", freeze, 1'b0);
        check("reset_isr_index", isr_index, 3'd0);
        check("reset_set_isr", set_isr, 1'b0);
        check("reset_ack_done", ack_done, 1'b0);
        rst_n = 1'b1;
        wait_cycles(4);

        run_seq(1'b0, 1'b1, 8'h40, 8'h04, 1'b1, 3'd2, 3'd0, 1'b0);
        run_seq(1'b0, 1'b1, 8'h40, 8'h04, 1'b1, 3'd5, 3'd0, 1'b0);
        run_seq(1'b0, 1'b0, 8'h70, 8'h02, 1'b1, 3'd3, 3'd2, 1'b0);
        run_seq(1'b0, 1'b0, 8'h70, 8'h02, 1'b1, 3'd3, 3'd4, 1'b0);
        run_seq(1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 3'd1, 3'd0, 1'b0);
        run_seq(1'b1, 1'b1, 8'h08, 8'hFF, 1'b1, 3'd1, 3'd0, 1'b1);
        run_seq(1'b0, 1'b1, 8'h58, 8'h10, 1'b1, 3'd4, 3'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_seq(1'($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 4) != 0), 3'($urandom),
                    3'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
